// File: rtl/bsg_downstream_rx.sv
`default_nettype none
// ============================================================================
// Module   : bsg_downstream_rx
// Brief    : Link receive end: deserialises two-channel phases into bytes,
//            buffers them for the core and returns credit tokens upstream.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_downstream_rx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TOKEN_BYTES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          io_valid_in,
    input  logic                          io_data_in_ch0,
    input  logic                          io_data_in_ch1,
    output logic                          io_token_out,
    output logic [7:0]                    core_data_out,
    output logic                          core_valid_out,
    input  logic                          core_yumi_in,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow_err,
    output logic                          framing_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CRD_W = $clog2(TOKEN_BYTES) + 1;

    localparam logic [CNT_W-1:0] c_depth       = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one     = PTR_W'(1);
    localparam logic [CRD_W-1:0] c_crd_one     = CRD_W'(1);
    localparam logic [CRD_W-1:0] c_credit_last = CRD_W'(TOKEN_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P    = 2'd1,
        ST_N    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_p_phase;
    logic             w_n_phase;

    logic             r_bit0;
    logic             r_bit2;
    logic             r_nib_hi;
    logic [3:0]       r_low_nib;
    logic [3:0]       w_nibble;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_byte_wr;
    logic             w_wr_ok;
    logic             w_pop;

    logic [CRD_W-1:0] r_credit;
    logic             r_token;
    logic             r_overflow;
    logic             r_framing;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The slot after a p-phase is always the n-phase; a valid seen there is a
    // framing fault, never the start of a new nibble, so ST_P just waits again.
    always_comb begin
        w_p_phase    = 1'b0;
        w_n_phase    = 1'b0;
        w_state_next = ST_IDLE;
        case (r_state)
            ST_N: begin
                w_n_phase = 1'b1;
                if (io_valid_in) begin
                    w_state_next = ST_P;
                end
            end
            default: begin
                if (io_valid_in) begin
                    w_p_phase    = 1'b1;
                    w_state_next = ST_N;
                end
            end
        endcase
    end

    assign w_nibble  = {io_data_in_ch1, r_bit2, io_data_in_ch0, r_bit0};
    assign w_byte_wr = w_n_phase && r_nib_hi;
    assign w_pop     = core_yumi_in && (r_count != '0);
    assign w_wr_ok   = w_byte_wr && ((r_count < c_depth) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit0     <= 1'b0;
            r_bit2     <= 1'b0;
            r_nib_hi   <= 1'b0;
            r_low_nib  <= 4'h0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_credit   <= '0;
            r_token    <= 1'b0;
            r_overflow <= 1'b0;
            r_framing  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            r_token <= 1'b0;
            if (w_p_phase) begin
                r_bit0 <= io_data_in_ch0;
                r_bit2 <= io_data_in_ch1;
            end
            if (w_n_phase) begin
                r_nib_hi <= ~r_nib_hi;
                if (!r_nib_hi) begin
                    r_low_nib <= w_nibble;
                end
                if (io_valid_in) begin
                    r_framing <= 1'b1;
                end
            end
            if (w_byte_wr && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end
            if (w_wr_ok) begin
                r_mem[r_wr_ptr] <= {w_nibble, r_low_nib};
                r_wr_ptr        <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
                if (r_credit == c_credit_last) begin
                    r_credit <= '0;
                    r_token  <= 1'b1;
                end else begin
                    r_credit <= r_credit + c_crd_one;
                end
            end
            if (w_wr_ok && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_wr_ok && w_pop) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    assign io_token_out   = r_token;
    assign core_data_out  = r_mem[r_rd_ptr];
    assign core_valid_out = (r_count != '0);
    assign fifo_count     = r_count;
    assign overflow_err   = r_overflow;
    assign framing_err    = r_framing;

endmodule
`default_nettype wire

// File: tb/tb_bsg_downstream_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_downstream_rx
// Brief    : Directed self-checking bench for bsg_downstream_rx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_downstream_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       io_valid_in = 1'b0;
    logic       io_data_in_ch0 = 1'b0;
    logic       io_data_in_ch1 = 1'b0;
    logic       io_token_out;
    logic [7:0] core_data_out;
    logic       core_valid_out;
    logic       core_yumi_in = 1'b0;
    logic [2:0] fifo_count;
    logic       overflow_err;
    logic       framing_err;

    int tests_run = 0;
    int tests_failed = 0;

    bsg_downstream_rx #(
        .FIFO_DEPTH  (4),
        .TOKEN_BYTES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .io_valid_in    (io_valid_in),
        .io_data_in_ch0 (io_data_in_ch0),
        .io_data_in_ch1 (io_data_in_ch1),
        .io_token_out   (io_token_out),
        .core_data_out  (core_data_out),
        .core_valid_out (core_valid_out),
        .core_yumi_in   (core_yumi_in),
        .fifo_count     (fifo_count),
        .overflow_err   (overflow_err),
        .framing_err    (framing_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        io_valid_in = 1'b0;
        io_data_in_ch0 = 1'b0;
        io_data_in_ch1 = 1'b0;
        core_yumi_in = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // p-phase then n-phase; optional pop asserted during the n-phase slot
    task automatic send_nib(input logic [3:0] n, input logic yumi_on_n);
        io_valid_in = 1'b1;
        io_data_in_ch0 = n[0];
        io_data_in_ch1 = n[2];
        step();
        io_valid_in = 1'b0;
        io_data_in_ch0 = n[1];
        io_data_in_ch1 = n[3];
        core_yumi_in = yumi_on_n;
        step();
        core_yumi_in = 1'b0;
        io_data_in_ch0 = 1'b0;
        io_data_in_ch1 = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic yumi_on_last);
        send_nib(b[3:0], 1'b0);
        send_nib(b[7:4], yumi_on_last);
    endtask

    task automatic pop();
        core_yumi_in = 1'b1;
        step();
        core_yumi_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({io_token_out, core_valid_out, overflow_err, framing_err} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 0000",
                     {io_token_out, core_valid_out, overflow_err, framing_err});
        end
        tests_run++;
        if (core_data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_data: got %h want 00", core_data_out);
        end
        tests_run++;
        if (fifo_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_count: got %0d want 0", fifo_count);
        end
        pop();
        tests_run++;
        if (fifo_count !== 3'd0 || core_valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL empty_yumi: count %0d valid %b want 0 0", fifo_count, core_valid_out);
        end
    endtask

    task automatic test_single_byte();
        do_reset();
        send_byte(8'hA5, 1'b0);
        tests_run++;
        if (core_valid_out !== 1'b1 || core_data_out !== 8'hA5) begin
            tests_failed++;
            $display("FAIL single_byte: valid %b data %h want 1 a5", core_valid_out, core_data_out);
        end
        tests_run++;
        if (fifo_count !== 3'd1 || io_token_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_count: count %0d token %b want 1 0", fifo_count, io_token_out);
        end
        pop();
        tests_run++;
        if (fifo_count !== 3'd0 || io_token_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_pop: count %0d token %b want 0 0", fifo_count, io_token_out);
        end
    endtask

    task automatic test_token();
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(exp_b[i], 1'b0);
        tests_run++;
        if (fifo_count !== 3'd4 || io_token_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL token_fill: count %0d token %b want 4 0", fifo_count, io_token_out);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (core_data_out !== exp_b[i]) begin
                tests_failed++;
                $display("FAIL token_order[%0d]: got %h want %h", i, core_data_out, exp_b[i]);
            end
            core_yumi_in = 1'b1;
            step();
            tests_run++;
            if (io_token_out !== (i % 2 == 1)) begin
                tests_failed++;
                $display("FAIL token_pulse[%0d]: got %b want %b", i, io_token_out, (i % 2 == 1));
            end
        end
        core_yumi_in = 1'b0;
        step();
        tests_run++;
        if (io_token_out !== 1'b0 || fifo_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL token_after: token %b count %0d want 0 0", io_token_out, fifo_count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send_byte(8'hB1, 1'b0);
        send_byte(8'hB2, 1'b0);
        send_byte(8'hB3, 1'b0);
        send_byte(8'hB4, 1'b0);
        tests_run++;
        if (overflow_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_early: got %b want 0", overflow_err);
        end
        send_byte(8'h5A, 1'b0);
        tests_run++;
        if (overflow_err !== 1'b1 || fifo_count !== 3'd4 || core_data_out !== 8'hB1) begin
            tests_failed++;
            $display("FAIL ovf_drop: err %b count %0d head %h want 1 4 b1",
                     overflow_err, fifo_count, core_data_out);
        end
        pop();
        send_byte(8'h6C, 1'b0);
        tests_run++;
        if (fifo_count !== 3'd4 || core_data_out !== 8'hB2) begin
            tests_failed++;
            $display("FAIL ovf_refill: count %0d head %h want 4 b2", fifo_count, core_data_out);
        end
        pop();
        pop();
        pop();
        tests_run++;
        if (core_data_out !== 8'h6C || fifo_count !== 3'd1 || overflow_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_tail: head %h count %0d err %b want 6c 1 1",
                     core_data_out, fifo_count, overflow_err);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        send_byte(8'hC3, 1'b0);
        send_byte(8'hC4, 1'b0);
        send_byte(8'h77, 1'b1);
        tests_run++;
        if (overflow_err !== 1'b0 || fifo_count !== 3'd4 || core_data_out !== 8'hC2) begin
            tests_failed++;
            $display("FAIL full_pop: err %b count %0d head %h want 0 4 c2",
                     overflow_err, fifo_count, core_data_out);
        end
        pop();
        pop();
        pop();
        tests_run++;
        if (core_data_out !== 8'h77 || fifo_count !== 3'd1) begin
            tests_failed++;
            $display("FAIL full_pop_tail: head %h count %0d want 77 1", core_data_out, fifo_count);
        end
    endtask

    task automatic test_framing();
        do_reset();
        io_valid_in = 1'b1;
        io_data_in_ch0 = 1'b1;
        io_data_in_ch1 = 1'b0;
        step();
        io_data_in_ch0 = 1'b1;
        io_data_in_ch1 = 1'b1;
        step();
        io_valid_in = 1'b0;
        io_data_in_ch0 = 1'b0;
        io_data_in_ch1 = 1'b0;
        tests_run++;
        if (framing_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL framing_flag: got %b want 1", framing_err);
        end
        // low nibble was captured as 4'hB; the next nibble completes the byte
        send_nib(4'h4, 1'b0);
        tests_run++;
        if (core_data_out !== 8'h4B || fifo_count !== 3'd1 || framing_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL framing_data: head %h count %0d err %b want 4b 1 1",
                     core_data_out, fifo_count, framing_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_nib(4'hE, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        send_byte(8'hC3, 1'b0);
        tests_run++;
        if (core_data_out !== 8'hC3 || fifo_count !== 3'd1) begin
            tests_failed++;
            $display("FAIL reset_mid: head %h count %0d want c3 1", core_data_out, fifo_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_token();
        test_overflow();
        test_full_pop();
        test_framing();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
